// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bus bundle between the interconnect master port and the register-file slave.
// Write channels AW/W/B and read channels AR/R; the clock and reset travel separately.
interface axil_reg_slave_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register-file slave with independent write (AW/W/B) and read (AR/R) FSMs.
// Define AXIL_REG_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axil_reg_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                           s0_axi_aclk,
    input  logic                           s0_axi_areset,
    axil_reg_slave_if.slave                s0_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int RI_W   = $clog2(NUM_REGS);

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REG_SLVERR_EN
    localparam logic [1:0] RESP_MISS = 2'b10;
`else
    localparam logic [1:0] RESP_MISS = 2'b00;
`endif

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_RESP = 1'b1;

    function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE;
        return (a >= BASE) && ((off >> 2) < ADDR_WIDTH'(NUM_REGS));
    endfunction

    function automatic logic [RI_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = (a - BASE) >> 2;
        return RI_W'(off);
    endfunction

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic [0:0]            wstate;
    logic                  awready_q, wready_q, bvalid_q;
    logic [1:0]            bresp_q;
    logic                  aw_done, w_done;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;

    logic [0:0]            rstate;
    logic                  arready_q, rvalid_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  aw_hs, w_hs, ar_hs, wr_fire, wr_hit, rd_hit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic [RI_W-1:0]       wr_idx, rd_idx;

    // A half-latched write takes whichever of address/data is already held, the rest live.
    always_comb begin
        aw_hs   = s0_axi.awvalid & awready_q;
        w_hs    = s0_axi.wvalid & wready_q;
        ar_hs   = s0_axi.arvalid & arready_q;
        wr_addr = aw_done ? aw_addr_q : s0_axi.awaddr;
        wr_data = w_done ? w_data_q : s0_axi.wdata;
        wr_strb = w_done ? w_strb_q : s0_axi.wstrb;
        wr_fire = (wstate == W_IDLE) & (aw_done | aw_hs) & (w_done | w_hs);
        wr_hit  = addr_hit(wr_addr);
        wr_idx  = addr_idx(wr_addr);
        rd_hit  = addr_hit(s0_axi.araddr);
        rd_idx  = addr_idx(s0_axi.araddr);
    end

    always_ff @(posedge s0_axi_aclk) begin
        if (s0_axi_areset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_fire && wr_hit) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (wr_strb[k]) regs[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge s0_axi_aclk) begin
        if (aw_hs) aw_addr_q <= s0_axi.awaddr;
        if (w_hs) begin
            w_data_q <= s0_axi.wdata;
            w_strb_q <= s0_axi.wstrb;
        end
    end

    always_ff @(posedge s0_axi_aclk) begin
        if (s0_axi_areset) begin
            wstate       <= W_IDLE;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            bvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            reg_wr_pulse <= '0;
        end else begin
            reg_wr_pulse <= '0;
            case (wstate)
                W_IDLE: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs) w_done <= 1'b1;
                    if (wr_fire) begin
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= wr_hit ? RESP_OKAY : RESP_MISS;
                        for (int i = 0; i < NUM_REGS; i++)
                            reg_wr_pulse[i] <= wr_hit && (wr_idx == RI_W'(i));
                        wstate    <= W_RESP;
                    end else begin
                        awready_q <= ~(aw_done | aw_hs);
                        wready_q  <= ~(w_done | w_hs);
                    end
                end
                W_RESP: begin
                    if (s0_axi.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wstate    <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Read data is sampled before any same-edge write lands, so it returns the old value.
    always_ff @(posedge s0_axi_aclk) begin
        if (s0_axi_areset) begin
            rstate    <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (ar_hs) begin
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rd_hit ? regs[rd_idx] : '0;
                        rresp_q   <= rd_hit ? RESP_OKAY : RESP_MISS;
                        rstate    <= R_RESP;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (s0_axi.rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rstate    <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

    assign s0_axi.awready = awready_q;
    assign s0_axi.wready  = wready_q;
    assign s0_axi.bvalid  = bvalid_q;
    assign s0_axi.bresp   = bresp_q;
    assign s0_axi.arready = arready_q;
    assign s0_axi.rvalid  = rvalid_q;
    assign s0_axi.rresp   = rresp_q;
    assign s0_axi.rdata   = rdata_q;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave: reset, aligned and split writes, stalled reads,
// out-of-range accesses, same-cycle read/write and reset during a pending response.
module tb_axil_reg_slave;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] reg_q;
    logic [7:0]   reg_wr_pulse;
    int           total = 0;
    int           bad   = 0;
    logic [31:0]  model [8];

`ifdef AXIL_REG_SLVERR_EN
    localparam logic [1:0] MISS = 2'b10;
`else
    localparam logic [1:0] MISS = 2'b00;
`endif

    axil_reg_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    axil_reg_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(8), .BASE_ADDR(0)) dut (
        .s0_axi_aclk   (clk),
        .s0_axi_areset (rst),
        .s0_axi        (bus),
        .reg_q         (reg_q),
        .reg_wr_pulse  (reg_wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] exp_q();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = model[i];
        return v;
    endfunction

    task automatic idle_bus();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.arvalid = 1'b0;
    endtask

    task automatic drive_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.awaddr  = a;
        bus.awvalid = 1'b1;
        bus.wdata   = d;
        bus.wstrb   = s;
        bus.wvalid  = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) model[i] = 32'h0;
        rst         = 1'b1;
        bus.awaddr  = 8'h00;
        bus.awvalid = 1'b1;
        bus.wdata   = 32'h0;
        bus.wstrb   = 4'h0;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b1;
        bus.araddr  = 8'h00;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b0;

        // reset held for three edges with all valids up
        tick();
        chk("rst_readys_e1", {bus.awready, bus.wready, bus.arready}, 3'b000);
        tick();
        tick();
        chk("rst_readys_e3", {bus.awready, bus.wready, bus.arready}, 3'b000);
        chk("rst_valids", {bus.bvalid, bus.rvalid}, 2'b00);
        chk("rst_reg_q", reg_q, 256'h0);
        chk("rst_pulse", reg_wr_pulse, 8'h00);
        rst = 1'b0;
        idle_bus();
        tick();
        chk("rel_readys", {bus.awready, bus.wready, bus.arready}, 3'b111);
        chk("rel_valids", {bus.bvalid, bus.rvalid}, 2'b00);

        // aligned write of reg 1, AW and W in the same cycle
        drive_wr(8'h04, 32'hDEADBEEF, 4'hF);
        tick();
        model[1] = 32'hDEADBEEF;
        idle_bus();
        chk("w1_reg_q", reg_q, exp_q());
        chk("w1_pulse", reg_wr_pulse, 8'b0000_0010);
        chk("w1_b", {bus.bvalid, bus.bresp}, 3'b100);
        tick();
        chk("w1_b_done", bus.bvalid, 1'b0);
        chk("w1_pulse_clr", reg_wr_pulse, 8'h00);
        chk("w1_rearm", {bus.awready, bus.wready}, 2'b11);

        // seed reg 2, then W ahead of AW by three cycles
        drive_wr(8'h08, 32'h11223344, 4'hF);
        tick();
        model[2] = 32'h11223344;
        idle_bus();
        tick();
        bus.wdata  = 32'h000000AA;
        bus.wstrb  = 4'h1;
        bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        chk("wfirst_wready", {bus.wready, bus.awready, bus.bvalid}, 3'b010);
        tick();
        tick();
        chk("wfirst_wait", {bus.wready, bus.bvalid, reg_wr_pulse}, {2'b00, 8'h00});
        bus.awaddr  = 8'h08;
        bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        model[2] = 32'h112233AA;
        chk("wfirst_b", {bus.bvalid, bus.bresp}, 3'b100);
        chk("wfirst_reg_q", reg_q, exp_q());
        chk("wfirst_pulse", reg_wr_pulse, 8'b0000_0100);
        tick();

        // read of reg 1 stalled by rready low for four cycles
        bus.araddr  = 8'h04;
        bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rd_stall%0d", i), {bus.rvalid, bus.arready, bus.rresp, bus.rdata},
                {1'b1, 1'b0, 2'b00, 32'hDEADBEEF});
            if (i < 3) tick();
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        chk("rd_done", {bus.rvalid, bus.arready}, 2'b01);

        // out-of-range write and read at 0x40
        drive_wr(8'h40, 32'hFFFFFFFF, 4'hF);
        tick();
        idle_bus();
        chk("miss_w_b", {bus.bvalid, bus.bresp}, {1'b1, MISS});
        chk("miss_w_pulse", reg_wr_pulse, 8'h00);
        chk("miss_w_reg_q", reg_q, exp_q());
        tick();
        bus.araddr  = 8'h40;
        bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        chk("miss_r", {bus.rvalid, bus.rresp, bus.rdata}, {1'b1, MISS, 32'h0});
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;

        // reg 3 = 1, then write 0x55 and read it in the same cycle
        drive_wr(8'h0C, 32'h00000001, 4'hF);
        tick();
        model[3] = 32'h1;
        idle_bus();
        tick();
        drive_wr(8'h0C, 32'h00000055, 4'hF);
        bus.araddr  = 8'h0C;
        bus.arvalid = 1'b1;
        tick();
        idle_bus();
        model[3] = 32'h55;
        chk("rw_same_rdata", {bus.rvalid, bus.rdata}, {1'b1, 32'h00000001});
        chk("rw_same_reg_q", reg_q, exp_q());
        chk("rw_same_pulse", reg_wr_pulse, 8'b0000_1000);
        bus.rready = 1'b1;
        tick();
        bus.rready  = 1'b0;
        bus.araddr  = 8'h0C;
        bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        chk("rw_reread", {bus.rvalid, bus.rdata}, {1'b1, 32'h00000055});
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;

        // reset while a B response is pending
        bus.bready = 1'b0;
        drive_wr(8'h00, 32'h00000077, 4'hF);
        tick();
        idle_bus();
        model[0] = 32'h77;
        chk("bhold_1", {bus.bvalid, reg_q[31:0]}, {1'b1, 32'h77});
        tick();
        chk("bhold_2", {bus.bvalid, bus.awready, bus.wready}, 3'b100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 32'h0;
        chk("rst_b_drop", {bus.bvalid, bus.awready, bus.wready, bus.arready}, 4'b0000);
        chk("rst_b_reg_q", reg_q, exp_q());
        bus.bready = 1'b1;
        tick();
        chk("rst_b_rearm", {bus.awready, bus.wready, bus.arready}, 3'b111);
        tick();
        tick();
        chk("rst_b_no_b", {bus.bvalid, bus.rvalid, reg_wr_pulse}, {2'b00, 8'h00});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
